display_arbiter: RTL and testbench

Schedules and shares the 4-digit seven-segment display between three sources: live time, time-set editing, and one-shot messages such as alarm or AM/PM banners. It drives the 16-bit BCD word consumed by the seven-segment controller, four digits of 4 bits with digit 0 at [3:0].
Priority is set mode > message > time. The block blinks the digit under edit and holds accepted messages for a timed interval.

---
 rtl/display_arbiter.sv | 150 +++++++++++++++
 tb/tb_display_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Shares the 4-digit BCD display between live time, time-set editing (blinking digit) and timed messages.
// Registered outputs follow the selected source one cycle later; a message request is held until msg_ack_o.
module display_arbiter #(
   parameter int unsigned TICK_DIV   = 100000,
   parameter int unsigned BLINK_HALF = 250,
   parameter int unsigned HOLD_TICKS = 2000,
   parameter logic [3:0]  BLANK_CODE = 4'hF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] time_bcd_i,
   input  logic        set_active_i,
   input  logic [1:0]  set_digit_i,
   input  logic [15:0] set_bcd_i,
   input  logic        msg_req_i,
   input  logic [15:0] msg_bcd_i,
   output logic        msg_ack_o,
   output logic        msg_done_o,
   output logic [15:0] bcd_out_o,
   output logic [1:0]  src_o
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned BW = $clog2(BLINK_HALF + 1);
   localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {
      S_TIME = 2'b00,
      S_SET  = 2'b01,
      S_MSG  = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   logic [1:0]    digit_q;
   logic [HW-1:0] hold_q, hold_d;
   logic [15:0]   msg_q, msg_d;
   logic [15:0]   bcd_q, bcd_d;
   logic [1:0]    src_q;
   logic          ack_q, ack_d;
   logic          done_q, done_d;
   logic          tick;
   logic [15:0]   set_word;

   assign tick = (presc_q == PW'(TICK_DIV - 1));

   always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      hold_d  = hold_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_TIME: begin
            if (set_active_i) begin
               state_d = S_SET;
            end else if (msg_req_i) begin
               ack_d   = 1'b1;
               msg_d   = msg_bcd_i;
               hold_d  = HW'(HOLD_TICKS);
               state_d = S_MSG;
            end
         end
         S_MSG: begin
            // Editing pre-empts a message outright; it is dropped without msg_done.
            if (set_active_i) begin
               state_d = S_SET;
            end else if (tick) begin
               if (hold_q == HW'(1)) begin
                  done_d  = 1'b1;
                  state_d = S_TIME;
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end
         end
         S_SET: begin
            if (!set_active_i) state_d = S_TIME;
         end
         default: state_d = S_TIME;
      endcase
   end

   // Entering set mode or moving to another digit restarts the blink visible.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if ((state_d == S_SET && state_q != S_SET) || (set_digit_i != digit_q)) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (state_q == S_SET && tick) begin
         if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      set_word = set_bcd_i;
      if (phase_d) set_word[{set_digit_i, 2'b00} +: 4] = BLANK_CODE;
      case (state_d)
         S_SET:   bcd_d = set_word;
         S_MSG:   bcd_d = msg_d;
         default: bcd_d = time_bcd_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_TIME;
         presc_q     <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         digit_q     <= 2'b00;
         hold_q      <= '0;
         msg_q       <= 16'h0000;
         bcd_q       <= 16'h0000;
         src_q       <= 2'b00;
         ack_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         digit_q     <= set_digit_i;
         hold_q      <= hold_d;
         msg_q       <= msg_d;
         bcd_q       <= bcd_d;
         src_q       <= state_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
      end
   end

   assign msg_ack_o  = ack_q;
   assign msg_done_o = done_q;
   assign bcd_out_o  = bcd_q;
   assign src_o      = src_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with TICK_DIV=4, BLINK_HALF=2, HOLD_TICKS=3.
module tb_display_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] time_bcd;
   logic        set_active;
   logic [1:0]  set_digit;
   logic [15:0] set_bcd;
   logic        msg_req;
   logic [15:0] msg_bcd;
   logic        msg_ack;
   logic        msg_done;
   logic [15:0] bcd_out;
   logic [1:0]  src;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   display_arbiter #(
      .TICK_DIV  (4),
      .BLINK_HALF(2),
      .HOLD_TICKS(3),
      .BLANK_CODE(4'hF)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .time_bcd_i  (time_bcd),
      .set_active_i(set_active),
      .set_digit_i (set_digit),
      .set_bcd_i   (set_bcd),
      .msg_req_i   (msg_req),
      .msg_bcd_i   (msg_bcd),
      .msg_ack_o   (msg_ack),
      .msg_done_o  (msg_done),
      .bcd_out_o   (bcd_out),
      .src_o       (src)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
      tests++;
      assert (v >= lo && v <= hi) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int lo, input int hi, input logic [15:0] tword);
      int k;
      logic early;
      k = 0;
      early = 1'b0;
      do begin
         step();
         k++;
         if (!msg_done && (src !== 2'b10 || msg_ack !== 1'b0)) early = 1'b1;
      end while (!msg_done && k < 20);
      chk_rng({tag, "_lat"}, k, lo, hi);
      chk({tag, "_held"}, 16'(early), 16'h0);
      chk({tag, "_src"}, 16'(src), 16'h0000);
      chk({tag, "_bcd"}, bcd_out, tword);
      step();
      chk({tag, "_pulse"}, 16'(msg_done), 16'h0);
   endtask

   initial begin
      int   n;
      logic bad;

      // 1: reset and live time
      rst_n = 1'b0; time_bcd = 16'h1259; set_active = 1'b0; set_digit = 2'd0;
      set_bcd = 16'h0000; msg_req = 1'b0; msg_bcd = 16'h0000;
      #1;
      chk("rst_bcd", bcd_out, 16'h0000);
      chk("rst_src", 16'(src), 16'h0000);
      chk("rst_ack", 16'(msg_ack), 16'h0);
      chk("rst_done", 16'(msg_done), 16'h0);
      step(); step();
      chk("rst_hold_bcd", bcd_out, 16'h0000);
      rst_n = 1'b1;
      step();
      chk("t1_bcd", bcd_out, 16'h1259);
      chk("t1_src", 16'(src), 16'h0000);
      time_bcd = 16'h0100;
      #1;
      chk("t1_latency", bcd_out, 16'h1259);
      step();
      chk("t1_bcd2", bcd_out, 16'h0100);

      // 2: message accepted and expires
      msg_bcd = 16'hA1A1; msg_req = 1'b1;
      step();
      chk("t2_ack", 16'(msg_ack), 16'h1);
      chk("t2_src", 16'(src), 16'h0002);
      chk("t2_bcd", bcd_out, 16'hA1A1);
      msg_req = 1'b0;
      step();
      chk("t2_ack_pulse", 16'(msg_ack), 16'h0);
      wait_done("t2_done", 8, 11, 16'h0100);

      // 3: set mode blink
      set_bcd = 16'h1030; set_digit = 2'd1; set_active = 1'b1;
      step();
      chk("t3_src", 16'(src), 16'h0001);
      chk("t3_vis", bcd_out, 16'h1030);
      n = 0;
      do begin step(); n++; end while (bcd_out == 16'h1030 && n < 12);
      chk_rng("t3_first_vis", n, 5, 8);
      chk("t3_blank", bcd_out, 16'h10F0);
      n = 0;
      do begin step(); n++; end while (bcd_out == 16'h10F0 && n < 20);
      chk("t3_blank_len", 16'(n), 16'd8);
      chk("t3_vis2", bcd_out, 16'h1030);
      n = 0;
      do begin step(); n++; end while (bcd_out == 16'h1030 && n < 20);
      chk("t3_vis_len", 16'(n), 16'd8);
      chk("t3_blank2", bcd_out, 16'h10F0);
      set_digit = 2'd2;
      step();
      chk("t3_newdig_vis", bcd_out, 16'h1030);
      n = 0;
      do begin step(); n++; end while (bcd_out == 16'h1030 && n < 12);
      chk_rng("t3_newdig_vis_len", n, 5, 8);
      chk("t3_newdig_blank", bcd_out, 16'h1F30);
      set_active = 1'b0;
      step();
      chk("t3_exit_src", 16'(src), 16'h0000);
      chk("t3_exit_bcd", bcd_out, 16'h0100);

      // 4: set pre-empts a message; pending request acked afterwards
      msg_bcd = 16'hBEEF; msg_req = 1'b1;
      step();
      chk("t4_ack", 16'(msg_ack), 16'h1);
      step(); step();
      chk("t4_no_reack", 16'(msg_ack), 16'h0);
      chk("t4_in_msg", 16'(src), 16'h0002);
      set_bcd = 16'h4321; set_digit = 2'd0; set_active = 1'b1;
      step();
      chk("t4_abort_src", 16'(src), 16'h0001);
      chk("t4_abort_bcd", bcd_out, 16'h4321);
      bad = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (msg_done !== 1'b0 || msg_ack !== 1'b0) bad = 1'b1;
      end
      chk("t4_quiet", 16'(bad), 16'h0);
      set_active = 1'b0;
      step();
      chk("t4_exit_src", 16'(src), 16'h0000);
      chk("t4_exit_ack", 16'(msg_ack), 16'h0);
      step();
      chk("t4_reack", 16'(msg_ack), 16'h1);
      chk("t4_reack_bcd", bcd_out, 16'hBEEF);
      msg_req = 1'b0;
      wait_done("t4_done", 8, 11, 16'h0100);

      // 5: simultaneous set and request
      msg_bcd = 16'h5A5A; msg_req = 1'b1; set_active = 1'b1; set_bcd = 16'h0000;
      step();
      chk("t5_src", 16'(src), 16'h0001);
      bad = msg_ack;
      for (int i = 0; i < 20; i++) begin
         step();
         if (msg_ack !== 1'b0) bad = 1'b1;
      end
      chk("t5_no_ack", 16'(bad), 16'h0);
      set_active = 1'b0;
      step();
      chk("t5_exit_ack", 16'(msg_ack), 16'h0);
      step();
      chk("t5_ack", 16'(msg_ack), 16'h1);
      chk("t5_bcd", bcd_out, 16'h5A5A);
      msg_req = 1'b0;

      // 6: reset while holding with two ticks left
      for (int i = 0; i < 4; i++) step();
      chk("t6_in_msg", 16'(src), 16'h0002);
      msg_bcd = 16'h7777; msg_req = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_bcd", bcd_out, 16'h0000);
      chk("t6_rst_src", 16'(src), 16'h0000);
      chk("t6_rst_done", 16'(msg_done), 16'h0);
      step(); step();
      chk("t6_rst_ack", 16'(msg_ack), 16'h0);
      rst_n = 1'b1;
      step();
      chk("t6_reack", 16'(msg_ack), 16'h1);
      chk("t6_reack_done", 16'(msg_done), 16'h0);
      chk("t6_reack_bcd", bcd_out, 16'h7777);
      msg_req = 1'b0;
      wait_done("t6_done", 8, 11, 16'h0100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
